// File: rtl/btn_sw_conditioner_pkg.sv
// Shared constants and helpers for the button/switch input conditioner.
package btn_sw_conditioner_pkg;

  localparam int unsigned NUM_BTNS  = 5;
  localparam int unsigned NUM_CARDS = 9;
  localparam int unsigned SW_W      = 16;

  localparam int unsigned BTN_CENTER = 0;
  localparam int unsigned BTN_TOP    = 1;
  localparam int unsigned BTN_BOTTOM = 2;
  localparam int unsigned BTN_LEFT   = 3;
  localparam int unsigned BTN_RIGHT  = 4;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_HOLD     = 2'd1;
  localparam logic [1:0] ST_WAIT_REL = 2'd2;

  function automatic logic is_onehot(input logic [NUM_CARDS-1:0] v);
    return (v != '0) && ((v & (v - NUM_CARDS'(1))) == '0);
  endfunction

  function automatic logic [3:0] onehot_index(input logic [NUM_CARDS-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_CARDS; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/btn_sw_conditioner_if.sv
// Board-side inputs and FSM-side card handshake of the input conditioner.
interface btn_sw_conditioner_if;
  import btn_sw_conditioner_pkg::*;

  logic [NUM_BTNS-1:0]  btn_raw;
  logic [SW_W-1:0]      sw_raw;
  logic [NUM_CARDS-1:0] hand_mask;
  logic [NUM_BTNS-1:0]  btn_pulse;
  logic                 card_valid;
  logic [NUM_CARDS-1:0] card_onehot;
  logic [3:0]           card_num;
  logic                 card_ack;
  logic                 sel_error;

  modport master (
    output btn_raw, sw_raw, hand_mask, card_ack,
    input  btn_pulse, card_valid, card_onehot, card_num, sel_error
  );

  modport slave (
    input  btn_raw, sw_raw, hand_mask, card_ack,
    output btn_pulse, card_valid, card_onehot, card_num, sel_error
  );

endinterface

// File: rtl/btn_sw_conditioner_debounce_cell.sv
// Two-flop synchroniser plus run-length debouncer for a WIDTH-bit group
// sharing one counter; the stable value changes after DEBOUNCE_CYCLES equal samples.
module debounce_cell #(
  parameter int unsigned WIDTH           = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] stable_o
);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] run_len;

  always_comb begin
    sync1_d  = raw_i;
    sync2_d  = sync1_q;
    last_d   = sync2_q;
    stable_d = stable_q;
    cnt_d    = '0;
    // A change of the synced vector mid-run restarts the count; for a single
    // bit this can only happen by returning to the stable level.
    if (cnt_q != '0 && sync2_q != last_q) run_len = CNT_W'(1);
    else                                  run_len = cnt_q + CNT_W'(1);
    if (sync2_q != stable_q) begin
      if (run_len == CNT_W'(DEBOUNCE_CYCLES)) stable_d = sync2_q;
      else                                    cnt_d    = run_len;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      last_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      last_q   <= last_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/btn_sw_conditioner.sv
// Input front end: debounced button press pulses and validated card selection
// presented to the game FSM with a valid/ack handshake.
module btn_sw_conditioner
  import btn_sw_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input logic                 clk,
  input logic                 reset_n,
  btn_sw_conditioner_if.slave bus
);

  logic [NUM_BTNS-1:0]  btn_stable;
  logic [NUM_CARDS-1:0] sw_stable;
  logic                 sw_hi_unused;

  assign sw_hi_unused = ^bus.sw_raw[SW_W-1:NUM_CARDS];

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    debounce_cell #(
      .WIDTH          (1),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_btn_db (
      .clk     (clk),
      .reset_n (reset_n),
      .raw_i   (bus.btn_raw[i]),
      .stable_o(btn_stable[i])
    );
  end

  debounce_cell #(
    .WIDTH          (NUM_CARDS),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_sw_db (
    .clk     (clk),
    .reset_n (reset_n),
    .raw_i   (bus.sw_raw[NUM_CARDS-1:0]),
    .stable_o(sw_stable)
  );

  logic [NUM_BTNS-1:0]  btn_prev_q, btn_prev_d;
  logic [NUM_BTNS-1:0]  btn_pulse_q, btn_pulse_d;
  logic [1:0]           state_q, state_d;
  logic                 card_valid_q, card_valid_d;
  logic [NUM_CARDS-1:0] card_onehot_q, card_onehot_d;
  logic [3:0]           card_num_q, card_num_d;
  logic                 sel_error_q, sel_error_d;
  logic                 confirm;

  assign confirm = btn_pulse_q[BTN_TOP];

  always_comb begin
    btn_prev_d    = btn_stable;
    btn_pulse_d   = btn_stable & ~btn_prev_q;
    state_d       = state_q;
    card_valid_d  = card_valid_q;
    card_onehot_d = card_onehot_q;
    card_num_d    = card_num_q;
    sel_error_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (confirm) begin
          if (is_onehot(sw_stable) && ((sw_stable & bus.hand_mask) != '0)) begin
            card_valid_d  = 1'b1;
            card_onehot_d = sw_stable;
            card_num_d    = onehot_index(sw_stable);
            state_d       = ST_HOLD;
          end else begin
            sel_error_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (bus.card_ack) begin
          card_valid_d  = 1'b0;
          card_onehot_d = '0;
          card_num_d    = '0;
          state_d       = ST_WAIT_REL;
        end
      end
      ST_WAIT_REL: begin
        // Switch must return to all-down before a new selection is accepted.
        if (sw_stable == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_prev_q    <= '0;
      btn_pulse_q   <= '0;
      state_q       <= ST_IDLE;
      card_valid_q  <= 1'b0;
      card_onehot_q <= '0;
      card_num_q    <= '0;
      sel_error_q   <= 1'b0;
    end else begin
      btn_prev_q    <= btn_prev_d;
      btn_pulse_q   <= btn_pulse_d;
      state_q       <= state_d;
      card_valid_q  <= card_valid_d;
      card_onehot_q <= card_onehot_d;
      card_num_q    <= card_num_d;
      sel_error_q   <= sel_error_d;
    end
  end

  assign bus.btn_pulse   = btn_pulse_q;
  assign bus.card_valid  = card_valid_q;
  assign bus.card_onehot = card_onehot_q;
  assign bus.card_num    = card_num_q;
  assign bus.sel_error   = sel_error_q;

endmodule
